wb_uart_rx: RTL
===============

# wb_uart_rx

Wishbone-slave UART receiver: the receive direction of the system UART, fed from the board `uart_rxd` pin and read by the CPU through `cpuif` on `sys_clk`. It deserialises 8N1 frames at a fixed bit period and buffers received bytes in a FIFO. It exposes data and status registers, plus a level interrupt that is asserted while data is pending.

## Interface
- `CLK_DIV`, 217: clock cycles per bit, minimum 4.
- `FIFO_DEPTH`, 16: receive FIFO entries, power of two, 2..128.
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `rxd`  in  1  asynchronous serial input, idle high.
- `cyc_i`  in  1  Wishbone cycle.
- `stb_i`  in  1  Wishbone strobe, already address-decoded.
- `we_i`  in  1  write enable.
- `adr_i`  in  30  word address; only `adr_i[0]` is decoded.
- `dat_i`  in  32  write data, ignored.
- `sel_i`  in  4  byte selects, ignored.
- `ack_o`  out  1  single-cycle acknowledge.
- `dat_o`  out  32  read data, registered.
- `irq_o`  out  1  high while the FIFO is non-empty, registered.

## Operation
- **Input path:** `rxd` passes through a 2-flop synchroniser; both flops reset to 1. A falling-edge detector uses the synchronised bit and its previous value.
- **FSM states:** IDLE, START, DATA, STOP. A down-counter `cnt` and a 3-bit `bitcnt` run the bit timing.
  - IDLE: a falling edge moves to START and loads `cnt = CLK_DIV/2 - 1`. A line held low never re-triggers; a new high-to-low edge is required.
  - START: at `cnt == 0`, sample the line. If it is 0, go to DATA with `cnt = CLK_DIV-1` and `bitcnt = 0`. If it is 1 (glitch), go back to IDLE with no side effects.
  - DATA: at `cnt == 0`, shift the sample in LSB first and reload `cnt`. After the 8th bit, go to STOP.
  - STOP: at `cnt == 0`, sample the line and go to IDLE.
    - Sample 1 and FIFO not full: push the byte.
    - Sample 1 and FIFO full: drop the byte and set sticky `overrun`.
    - Sample 0: discard the byte and set sticky `frame_err`.
- **FIFO:** read/write pointers are log2(FIFO_DEPTH)+1 bits wide, so the count ranges 0..FIFO_DEPTH.
  - Fullness is evaluated before any same-cycle pop. A push into a full FIFO is rejected even if a pop happens in the same cycle.
  - A simultaneous push (non-full) and pop leaves the count unchanged.
- **Register map (reads):**
  - `adr_i[0]=0` is DATA. `dat_o[7:0]` is the FIFO head and the upper bits are 0. The read pops the FIFO in the ack cycle if it is non-empty. Reading an empty FIFO returns 0 and changes nothing.
  - `adr_i[0]=1` is STATUS:
    - bit0 is non-empty.
    - bit1 is full.
    - bit2 is overrun.
    - bit3 is frame_err.
    - bits 15:8 are the count.
    - All other bits are 0.
  - Reading STATUS clears overrun and frame_err in the ack cycle. If a set event occurs in the same cycle, the set wins.
- **Writes** to either address are acknowledged and have no effect.
- **Reset:** ack_o, dat_o and irq_o go to 0. The FIFO is emptied, the flags are cleared, the FSM returns to IDLE and the counters are cleared. A frame in progress is abandoned; the next clean frame after release is received correctly.

## Timing
- **Wishbone:** ack_o rises one cycle after `cyc_i & stb_i` are sampled high while ack_o is low. It stays high for exactly one cycle. dat_o is valid in the same cycle as ack_o.
  - Back-to-back requests are acknowledged no more often than every 2nd cycle.
  - If cyc_i drops before ack, no ack is issued and no side effect occurs.
- **Sampling points:** the start bit is sampled at CLK_DIV/2 cycles after edge detection. Each data bit is sampled at intervals of CLK_DIV cycles after that, and the stop bit at CLK_DIV further.
- **Receive latency:** the STATUS non-empty bit and irq_o are high no later than 9.5·CLK_DIV + 4 cycles after the falling edge of the `rxd` start bit. The bound covers 2 synchroniser cycles, 1 edge-detect cycle and 1 push-register cycle.
- **Pop latency:** irq_o falls on the cycle after the ack that pops the last byte.

## Test plan
- **Two bytes:** CLK_DIV=8; send 0x55 then 0xA3 as 8N1.
  - STATUS reads 0x00000201.
  - DATA reads return 0x00000055, then 0x000000A3.
  - STATUS then reads 0x00000000 and irq_o=0.
- **Glitch:** drive `rxd` low for 2 cycles, then high.
  - FSM returns to IDLE, no push, STATUS reads 0.
  - A following 0x7E frame is received correctly.
- **Framing error:** send 0x3C with the stop bit at 0.
  - STATUS reads 0x00000008 and the FIFO stays empty.
  - A second STATUS read returns 0.
  - The line held low does not trigger a new frame until a high-to-low edge.
- **Overrun:** FIFO_DEPTH=16; send bytes 0x00..0x10 (17 frames) with no reads.
  - STATUS reads 0x00001007.
  - 16 DATA reads return 0x00..0x0F.
  - STATUS then reads 0.
- **Push/pop collision:** issue a DATA read whose ack lands on the stop-bit push cycle, with 3 bytes already queued.
  - The count stays 3 and the popped byte is the oldest.
  - The flag-set versus STATUS-clear collision leaves the flag set.
- **Reset mid-frame:** pulse `rst` during DATA bit 4, with 2 bytes queued.
  - ack_o, dat_o and irq_o go to 0 and STATUS reads 0.
  - The next frame, 0xC3, is read back exactly.

Source files
------------

// File: rtl/wb_uart_rx.sv
// Wishbone-slave UART receiver: 8N1 deserialiser at a fixed bit period feeding a
// byte FIFO, with DATA/STATUS registers and a level interrupt while data is pending.
module wb_uart_rx #(
    parameter int CLK_DIV    = 217,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [29:0] adr_i,
    input  logic [31:0] dat_i,
    input  logic [3:0]  sel_i,
    output logic        ack_o,
    output logic [31:0] dat_o,
    output logic        irq_o
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_LD = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LD = CW'(CLK_DIV - 1);
    localparam logic [AW:0]   DEPTH_V = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic unused_ok;
    assign unused_ok = ^{dat_i, sel_i, adr_i[29:1]};

    logic rx_s1, rx_s2, rx_prev;
    logic fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Edge-triggered start: a line parked low after a bad stop bit cannot restart.
    assign fall = rx_prev & ~rx_s2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          tick;

    assign tick = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            bitcnt <= '0;
            shreg  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fall) begin
                        state <= ST_START;
                        cnt   <= HALF_LD;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (!rx_s2) begin
                            state  <= ST_DATA;
                            cnt    <= FULL_LD;
                            bitcnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shreg  <= {rx_s2, shreg[7:1]};
                        cnt    <= FULL_LD;
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 3'd7) state <= ST_STOP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick) state <= ST_IDLE;
                    else      cnt   <= cnt - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic stop_tick, push_req, ferr_set;
    assign stop_tick = (state == ST_STOP) && tick;
    assign push_req  = stop_tick & rx_s2;
    assign ferr_set  = stop_tick & ~rx_s2;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wptr, rptr, fcount;
    logic        full, empty, push, pop, ovr_set;

    assign fcount  = wptr - rptr;
    assign full    = (fcount == DEPTH_V);
    assign empty   = (fcount == '0);
    // Fullness is judged before any same-cycle pop, so a pop never makes room for a push.
    assign push    = push_req & ~full;
    assign ovr_set = push_req & full;

    logic req, rd_data, rd_stat;
    assign req     = cyc_i & stb_i & ~ack_o;
    assign rd_data = req & ~we_i & ~adr_i[0];
    assign rd_stat = req & ~we_i &  adr_i[0];
    assign pop     = rd_data & ~empty;

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    logic        overrun, frame_err;
    logic [7:0]  count8;
    logic [31:0] status_word;

    assign count8      = 8'(fcount);
    assign status_word = {16'h0, count8, 4'h0, frame_err, overrun, full, ~empty};

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_o     <= 1'b0;
            dat_o     <= '0;
            irq_o     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ack_o <= req;
            if (rd_data)
                dat_o <= empty ? 32'h0 : {24'h0, mem[rptr[AW-1:0]]};
            else if (rd_stat)
                dat_o <= status_word;
            else
                dat_o <= '0;
            irq_o     <= ~empty;
            // A same-cycle set beats the read-to-clear.
            overrun   <= ovr_set  | (overrun   & ~rd_stat);
            frame_err <= ferr_set | (frame_err & ~rd_stat);
        end
    end

endmodule
